// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state and the per-register control bundle.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } ctrl_t;

  // Free-running pipeline: every register advances, nothing squashed.
  localparam ctrl_t CTRL_RUN = '{
    pc_en:        1'b1,
    if_id_en:     1'b1,
    if_id_flush:  1'b0,
    id_ex_en:     1'b1,
    id_ex_flush:  1'b0,
    ex_mem_en:    1'b1,
    mem_wb_flush: 1'b0
  };

  // Reset: everything frozen and every stage loads a bubble.
  localparam ctrl_t CTRL_RESET = '{
    pc_en:        1'b0,
    if_id_en:     1'b0,
    if_id_flush:  1'b1,
    id_ex_en:     1'b0,
    id_ex_flush:  1'b1,
    ex_mem_en:    1'b0,
    mem_wb_flush: 1'b1
  };

  // Everything frozen, no bubbles.
  localparam ctrl_t CTRL_HOLD = '0;

  // Saturating increment for the performance counters.
  function automatic logic sat_inc_en(input logic inc, input logic full);
    return inc & ~full;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard check between the ID instruction and a load in EX.
// x0 is hardwired to zero, so a load targeting it never stalls.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare each used source against the load destination.
  always_comb begin
    rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
    load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Outputs are combinational from state and inputs; counters saturate.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit NOP_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;
  ctrl_t            ctrl;
  logic             load_use;
  logic             mem_stall;
  logic             redir_inc;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req & ~mem_ready;

  // Priority mux: memory stall, new branch, redirect squash, load-use.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    redir_inc = 1'b0;
    priority case (1'b1)
      reset: begin
        ctrl    = NOP_ON_RESET ? CTRL_RESET : CTRL_HOLD;
        state_d = RUN;
      end
      mem_stall: begin
        ctrl              = CTRL_HOLD;
        ctrl.mem_wb_flush = 1'b1;
      end
      ex_branch_taken: begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        state_d          = REDIRECT;
        redir_inc        = 1'b1;
      end
      (state_q == REDIRECT): begin
        ctrl.if_id_flush = 1'b1;
        state_d          = RUN;
      end
      load_use: begin
        ctrl.pc_en       = 1'b0;
        ctrl.if_id_en    = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Next values of the saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if (sat_inc_en(~ctrl.pc_en, &stall_q))
      stall_d = stall_q + CNT_W'(1);
    if (sat_inc_en(redir_inc, &redir_q))
      redir_d = redir_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  end

  assign pc_en          = ctrl.pc_en;
  assign if_id_en       = ctrl.if_id_en;
  assign if_id_flush    = ctrl.if_id_flush;
  assign id_ex_en       = ctrl.id_ex_en;
  assign id_ex_flush    = ctrl.id_ex_flush;
  assign ex_mem_en      = ctrl.ex_mem_en;
  assign mem_wb_flush   = ctrl.mem_wb_flush;
  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with narrow counters so that
// saturation can be reached in a few cycles.
module tb_pipeline_ctrl;

  localparam int CW = 3;

  // Control vector order: pc,ifen,iff,iden,idf,exen,mwf
  localparam logic [6:0] V_RUN   = 7'b1101010;
  localparam logic [6:0] V_RST   = 7'b0010101;
  localparam logic [6:0] V_MST   = 7'b0000001;
  localparam logic [6:0] V_BR    = 7'b1010110;
  localparam logic [6:0] M_BR    = 7'b1010111;
  localparam logic [6:0] V_RD    = 7'b1011010;
  localparam logic [6:0] M_RD    = 7'b1011111;
  localparam logic [6:0] V_LU    = 7'b0000110;
  localparam logic [6:0] M_LU    = 7'b1110111;
  localparam logic [6:0] M_ALL   = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, if_id_en, if_id_flush;
  logic          id_ex_en, id_ex_flush, ex_mem_en;
  logic          mem_wb_flush;
  logic [CW-1:0] stall_cycles, redirect_count;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_ctrl #(.CNT_W(CW), .NOP_ON_RESET(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .redirect_count  (redirect_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {pc_en, if_id_en, if_id_flush, id_ex_en,
            id_ex_flush, ex_mem_en, mem_wb_flush};
  endfunction

  task automatic chk_ctl(input string tag,
                         input logic [6:0] exp,
                         input logic [6:0] msk);
    logic [6:0] obs;
    obs = ctl() & msk;
    n_cmp++;
    assert (obs === (exp & msk)) else begin
      n_bad++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, obs, exp & msk);
    end
  endtask

  task automatic chk_cnt(input string tag,
                         input logic [CW-1:0] s_exp,
                         input logic [CW-1:0] r_exp);
    n_cmp++;
    assert (stall_cycles === s_exp) else begin
      n_bad++;
      $error("FAIL %s stall obs=%0d exp=%0d", tag, stall_cycles, s_exp);
    end
    n_cmp++;
    assert (redirect_count === r_exp) else begin
      n_bad++;
      $error("FAIL %s redir obs=%0d exp=%0d", tag, redirect_count, r_exp);
    end
  endtask

  // Advance to the next cycle boundary for driving inputs.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); #1 chk_ctl("rst", V_RST, M_ALL);
    end
    nxt(); reset = 1'b0; #1;
    chk_ctl("post_rst", V_RUN, M_ALL);
    chk_cnt("post_rst", 3'd0, 3'd0);

    // 2: load-use on rs1
    nxt(); set_lu(); #1 chk_ctl("lu_rs1", V_LU, M_LU);
    nxt(); idle(); #1 chk_ctl("lu_rs1_after", V_RUN, M_ALL);
    chk_cnt("lu_rs1", 3'd1, 3'd0);

    // 3: same with ex_rd = x0
    nxt(); set_lu(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk_ctl("lu_x0", V_RUN, M_ALL);
    nxt(); idle(); #1 chk_cnt("lu_x0", 3'd1, 3'd0);

    // rs2 match triggers; rs1 match without use does not
    nxt(); ex_mem_read = 1'b1; ex_rd = 5'd9;
    id_rs2 = 5'd9; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1 chk_ctl("lu_rs2", V_LU, M_LU);
    nxt(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    #1 chk_ctl("lu_unused", V_RUN, M_ALL);
    chk_cnt("lu_rs2", 3'd2, 3'd0);

    // 4: branch, redirect with load-use ignored, then normal
    nxt(); idle(); ex_branch_taken = 1'b1; #1 chk_ctl("br", V_BR, M_BR);
    nxt(); idle(); set_lu(); #1 chk_ctl("br_redir", V_RD, M_RD);
    nxt(); idle(); #1 chk_ctl("br_done", V_RUN, M_ALL);
    chk_cnt("br", 3'd2, 3'd1);

    // 5: memory stall holds REDIRECT
    nxt(); ex_branch_taken = 1'b1; #1 chk_ctl("br2", V_BR, M_BR);
    for (int i = 0; i < 4; i++) begin
      nxt(); idle(); mem_req = 1'b1; #1 chk_ctl("mst_redir", V_MST, M_ALL);
    end
    nxt(); mem_ready = 1'b1; #1 chk_ctl("mst_release", V_RD, M_RD);
    nxt(); idle(); #1 chk_ctl("mst_run", V_RUN, M_ALL);
    chk_cnt("mst", 3'd6, 3'd2);

    // 6: memory stall beats branch and load-use
    nxt(); set_lu(); ex_branch_taken = 1'b1; mem_req = 1'b1;
    #1 chk_ctl("all3", V_MST, M_ALL);
    nxt(); idle(); #1 chk_ctl("all3_after", V_RUN, M_ALL);
    chk_cnt("all3", 3'd7, 3'd2);

    // stall counter saturates at all-ones
    nxt(); set_lu(); #1 chk_ctl("sat_lu", V_LU, M_LU);
    nxt(); idle(); #1 chk_cnt("sat_stall", 3'd7, 3'd2);

    // back-to-back branches, redirect counter saturates
    for (int i = 0; i < 6; i++) begin
      nxt(); ex_branch_taken = 1'b1; #1 chk_ctl("br_chain", V_BR, M_BR);
    end
    nxt(); idle(); #1 chk_ctl("br_chain_redir", V_RD, M_RD);
    chk_cnt("sat_redir", 3'd7, 3'd7);
    nxt(); #1 chk_ctl("br_chain_run", V_RUN, M_ALL);

    // reset during a memory stall clears counters on the same edge
    nxt(); mem_req = 1'b1; #1 chk_ctl("pre_rst_mst", V_MST, M_ALL);
    nxt(); reset = 1'b1; #1 chk_ctl("rst_mst", V_RST, M_ALL);
    nxt(); reset = 1'b0; idle(); #1;
    chk_ctl("rst_mst_after", V_RUN, M_ALL);
    chk_cnt("rst_mst", 3'd0, 3'd0);

    // reset while in REDIRECT returns to RUN
    nxt(); ex_branch_taken = 1'b1; #1 chk_ctl("br3", V_BR, M_BR);
    nxt(); idle(); reset = 1'b1; #1 chk_ctl("rst_redir", V_RST, M_ALL);
    nxt(); reset = 1'b0; #1 chk_ctl("rst_redir_after", V_RUN, M_ALL);
    chk_cnt("rst_redir", 3'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
